// File: rtl/bel_cscale.sv
// bel_cscale: complex sample scaler, rounding right shift with per-frame headroom
// Ports:
//    clk_i, rst_n_i             clock, synchronous active-low reset
//    a_re_i, a_im_i             signed input sample
//    shift_i, round_i, last_i   shift amount, round-half-up select, frame end marker
//    valid_i, ready_o           input handshake
//    x_re_o, x_im_o, last_o     scaled sample and its frame end marker
//    valid_o, ready_i           output handshake
//    headroom_o                 leading redundant sign bits over the last frame
//    headroom_valid_o           one-cycle strobe qualifying headroom_o
module bel_cscale #(
   parameter int word_width  = 16,
   parameter int shift_width = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic signed [word_width-1:0] a_re_i,
   input  logic signed [word_width-1:0] a_im_i,
   input  logic [shift_width-1:0]       shift_i,
   input  logic                         round_i,
   input  logic                         last_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic signed [word_width-1:0] x_re_o,
   output logic signed [word_width-1:0] x_im_o,
   output logic                         last_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [4:0]                   headroom_o,
   output logic                         headroom_valid_o
);
   localparam int w = word_width;
   localparam logic [31:0] smax = 32'(word_width - 1);
   logic [shift_width-1:0] s, s1_s;
   logic [w:0] rnd;
   logic signed [w:0] sum_re, sum_im, s1_re, s1_im;
   logic s1_valid, s1_last, s1_adv, xfer;
   // magnitude bits only: sign-folded msb is always zero, so it is not kept
   logic [w-2:0] term, acc, hv_vec;
   logic [4:0] lz;
   assign s1_adv  = !valid_o || ready_i;
   assign ready_o = !rst_n_i || !s1_valid || s1_adv;
   assign xfer    = valid_o && ready_i;
   always_comb begin
      s = (32'(shift_i) > smax) ? shift_width'(smax) : shift_i;
      rnd = (round_i && s != '0) ? (w+1)'(1) << (s - 1'b1) : '0;
      sum_re = {a_re_i[w-1], a_re_i} + rnd;
      sum_im = {a_im_i[w-1], a_im_i} + rnd;
      term = (x_re_o[w-2:0] ^ {(w-1){x_re_o[w-1]}}) | (x_im_o[w-2:0] ^ {(w-1){x_im_o[w-1]}});
      hv_vec = acc | term;
      // highest set bit wins, so an all-zero vector leaves word_width-1
      lz = 5'(smax);
      for (int i = 0; i < w-1; i++) if (hv_vec[i]) lz = 5'(w-2-i);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_valid         <= 1'b0;
         s1_last          <= 1'b0;
         s1_re            <= '0;
         s1_im            <= '0;
         s1_s             <= '0;
         valid_o          <= 1'b0;
         last_o           <= 1'b0;
         x_re_o           <= '0;
         x_im_o           <= '0;
         acc              <= '0;
         headroom_o       <= '0;
         headroom_valid_o <= 1'b0;
      end else begin
         if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
               s1_re   <= sum_re;
               s1_im   <= sum_im;
               s1_s    <= s;
               s1_last <= last_i;
            end
         end
         if (s1_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
               x_re_o <= w'(s1_re >>> s1_s);
               x_im_o <= w'(s1_im >>> s1_s);
               last_o <= s1_last;
            end
         end
         headroom_valid_o <= xfer && last_o;
         if (xfer) begin
            acc <= last_o ? '0 : hv_vec;
            if (last_o) headroom_o <= lz;
         end
      end
   end
endmodule
